// File: rtl/reg_arbiter_if.sv
// Bundle of request, grant and shared-register write signals between N_REQ
// requesters and the arbiter that owns the register.
interface reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int n     = 6
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*n-1:0] data_req;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   ack;
  logic [n-1:0]       reg_data;
  logic               reg_ce;
  logic [2:0]         owner;
  logic [7:0]         wr_count;

  modport master (
    output req, data_req,
    input  gnt, ack, reg_data, reg_ce, owner, wr_count
  );

  modport slave (
    input  req, data_req,
    output gnt, ack, reg_data, reg_ce, owner, wr_count
  );
endinterface

// File: rtl/reg_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto one n-bit register:
// each win runs GRANT -> WRITE (single REG_CE pulse) -> RELEASE until REQ drops.
module reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int n     = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  reg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       ownerIdx_q, ownerIdx_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       lastOwner_q, lastOwner_d;
  logic [n-1:0]     hold_q, hold_d;
  logic [7:0]       wrCount_q, wrCount_d;

  logic                 winValid;
  logic [2:0]           winIdx;
  logic [n-1:0]         winData;
  logic [2*N_REQ-1:0]   reqDouble;
  logic [N_REQ-1:0]     reqRot;
  logic [2:0]           winOff;
  logic [3:0]           winSum;
  logic                 ownerReq;
  logic [2:0]           ptrNext;
  logic                 regCe;
  logic [N_REQ-1:0]     ackVec;

  // Rotate REQ so bit 0 is the pointer's requester, then take the lowest set bit.
  always_comb begin
    reqDouble = {bus.req, bus.req} >> ptr_q;
    reqRot    = reqDouble[N_REQ-1:0];
    winValid  = |reqRot;
    winOff    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (reqRot[k]) winOff = 3'(k);
    end
    winSum = {1'b0, ptr_q} + {1'b0, winOff};
    if (winSum >= 4'(N_REQ)) winSum = winSum - 4'(N_REQ);
    winIdx  = winSum[2:0];
    winData = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (3'(k) == winIdx) winData = bus.data_req[k*n +: n];
    end
  end

  assign ownerReq = |(bus.req & gnt_q);
  assign ptrNext  = (ownerIdx_q == 3'(N_REQ - 1)) ? 3'd0 : ownerIdx_q + 3'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (winValid) state_d = GRANT;
      GRANT:   state_d = WRITE;
      WRITE:   state_d = RELEASE;
      RELEASE: if (!ownerReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    ownerIdx_d  = ownerIdx_q;
    ptr_d       = ptr_q;
    lastOwner_d = lastOwner_q;
    hold_d      = hold_q;
    wrCount_d   = wrCount_q;
    regCe       = 1'b0;
    ackVec      = '0;
    case (state_q)
      IDLE: begin
        if (winValid) begin
          gnt_d      = N_REQ'(1) << winIdx;
          ownerIdx_d = winIdx;
          hold_d     = winData;
        end
      end
      WRITE: begin
        regCe       = 1'b1;
        ackVec      = gnt_q;
        lastOwner_d = ownerIdx_q;
        wrCount_d   = wrCount_q + 8'd1;
        ptr_d       = ptrNext;
      end
      RELEASE: begin
        if (!ownerReq) gnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q       <= '0;
      ownerIdx_q  <= '0;
      ptr_q       <= '0;
      lastOwner_q <= '0;
      hold_q      <= '0;
      wrCount_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      ownerIdx_q  <= ownerIdx_d;
      ptr_q       <= ptr_d;
      lastOwner_q <= lastOwner_d;
      hold_q      <= hold_d;
      wrCount_q   <= wrCount_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ackVec;
  assign bus.reg_ce   = regCe;
  assign bus.reg_data = hold_q;
  assign bus.owner    = lastOwner_q;
  assign bus.wr_count = wrCount_q;

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one n-bit storage register; legal range 2..8.
REQ-002 Parameter n, default 6: data width of the shared register and of each requester's data word.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RESET  input  1: asynchronous, active-high reset; clears all state immediately, independent of CLK.
REQ-005 REQ  input  N_REQ: per-requester write request, level-sensitive; bit i belongs to requester i.
REQ-006 DATA_REQ  input  N_REQ*n: packed request data; requester i occupies bits [i*n+n-1 : i*n].
REQ-007 GNT  output  N_REQ: one-hot grant; all zero when no requester owns the register.
REQ-008 ACK  output  N_REQ: one-cycle completion pulse to the granted requester.
REQ-009 REG_DATA  output  n: data word driven to the shared register's data input.
REQ-010 REG_CE  output  1: write enable to the shared register; high for exactly one cycle per write.
REQ-011 OWNER  output  3: index of the last requester whose write completed.
REQ-012 WR_COUNT  output  8: total completed writes since reset.

Function
REQ-013 States: IDLE, GRANT, WRITE, RELEASE; encoding is free, reset state is IDLE.
REQ-014 IDLE: if any REQ bit is high, select the winner per round-robin (REQ-019), set its GNT bit, latch its DATA_REQ slice into an internal n-bit holding register, and go to GRANT; otherwise stay in IDLE with GNT=0.
REQ-015 GRANT: hold GNT; drive REG_DATA from the holding register; go to WRITE. REG_CE stays low.
REQ-016 WRITE: REG_CE=1 for this cycle only; REG_DATA = holding register; ACK bit of the owner =1 for this cycle; OWNER <= owner index; WR_COUNT <= WR_COUNT+1; go to RELEASE.
REQ-017 RELEASE: hold GNT; stay until the owner's REQ bit is low, then clear GNT and return to IDLE in the same transition. Other requesters are not considered while in RELEASE.
REQ-018 Latency: from REQ sampled high in IDLE to REG_CE high is exactly 2 cycles (IDLE->GRANT->WRITE); minimum spacing between two REG_CE pulses is 4 cycles.
REQ-019 Round-robin: a pointer P (reset 0) names the highest-priority index; the winner is the first REQ bit set scanning P, P+1, ..., wrapping modulo N_REQ; after WRITE, P <= owner+1 modulo N_REQ.
REQ-020 Data is captured only in IDLE; changes on DATA_REQ after the grant have no effect on REG_DATA.
REQ-021 A requester that drops REQ during GRANT or WRITE still completes its write; its RELEASE exits on the next cycle.
REQ-022 WR_COUNT wraps from 255 to 0 without any flag.
REQ-023 Outside WRITE, REG_CE=0 and ACK=0; REG_DATA holds the last latched value in every state.
REQ-024 GNT and ACK are never multi-hot; ACK is never asserted without the same GNT bit high.

Reset
REQ-025 While RESET=1: state=IDLE, GNT=0, ACK=0, REG_CE=0, REG_DATA=0, OWNER=0, WR_COUNT=0, P=0.
REQ-026 RESET asserted in any state (including WRITE) aborts the transaction with no further REG_CE; WR_COUNT keeps no partial increment.
REQ-027 After RESET deasserts, arbitration starts from the first rising CLK edge.

Verification
REQ-028 Single request: REQ=0010, requester 1 data=6'h2A -> GNT=0010 next cycle, REG_CE=1 with REG_DATA=6'h2A two cycles after REQ, ACK=0010 same cycle, OWNER=1, WR_COUNT=1.
REQ-029 Fairness: REQ=1111 held, each requester drops REQ one cycle after its ACK and re-raises it -> write order 0,1,2,3,0; no requester writes twice before all others have written once.
REQ-030 Pointer wrap: P=3 after owner 2, REQ=1001 -> requester 3 granted first, then requester 0.
REQ-031 Late-data: DATA_REQ of the owner changes from 6'h11 to 6'h3F in GRANT -> REG_DATA=6'h11 at REG_CE.
REQ-032 Reset mid-WRITE: RESET pulsed asynchronously during WRITE -> all outputs 0 immediately, no REG_CE afterwards until a new request, WR_COUNT=0.
REQ-033 Counter wrap: 256 completed writes -> WR_COUNT returns to 0, arbitration unaffected.
